// File: rtl/dmem_pkg.sv
// Shared definitions for the synchronous data memory: access-size codes,
// controller state encoding and the alignment-mask helper.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SZ_B:    align_mask = 3'b000;
      SZ_H:    align_mask = 3'b001;
      SZ_W:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: byte enables, load extraction (zero-extended,
// right-justified) and store merge into the addressed word.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [1:0]                  size_i,
  input  logic [$clog2(DATA_W/8)-1:0] off_i,
  input  logic [DATA_W-1:0]           wdata_i,
  input  logic [DATA_W-1:0]           word_i,
  output logic [DATA_W/8-1:0]         be_o,
  output logic [DATA_W-1:0]           merged_o,
  output logic [DATA_W-1:0]           rdata_o
);

  localparam int BYTES = DATA_W / 8;

  logic [BYTES-1:0]          size_be;
  logic [DATA_W-1:0]         size_mask;
  logic [DATA_W-1:0]         lane_mask;
  logic [$clog2(DATA_W)-1:0] bit_sh;

  always_comb begin
    size_be   = '0;
    size_mask = '0;
    lane_mask = '0;
    bit_sh    = {off_i, 3'b000};
    for (int b = 0; b < BYTES; b++) begin
      size_be[b] = (b < (1 << size_i));
    end
    be_o = size_be << off_i;
    for (int b = 0; b < BYTES; b++) begin
      size_mask[8*b +: 8] = {8{size_be[b]}};
      lane_mask[8*b +: 8] = {8{be_o[b]}};
    end
    rdata_o  = (word_i >> bit_sh) & size_mask;
    merged_o = (word_i & ~lane_mask) | ((wdata_i & size_mask) << bit_sh);
  end

endmodule

// File: rtl/sync_data_memory.sv
// Single-outstanding data memory with fixed request-to-response latency,
// sub-word little-endian accesses and alignment/range fault reporting.
module sync_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int         BYTES    = DATA_W / 8;
  localparam int         OFF_W    = $clog2(BYTES);
  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  logic [ADDR_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              misaligned, too_wide, out_of_range, fault, commit;
  logic [BYTES-1:0]  be;
  logic [DATA_W-1:0] merged, rd_extract;

  assign word_idx     = addr_q >> OFF_W;
  assign mem_idx      = word_idx[IDX_W-1:0];
  assign misaligned   = |(addr_q[2:0] & align_mask(size_q));
  assign too_wide     = (32'd1 << size_q) > 32'(BYTES);
  assign out_of_range = word_idx >= ADDR_W'(DEPTH);
  assign fault        = misaligned | too_wide | out_of_range;
  // The access completes on the WAIT->RESP edge; reset on that edge aborts it.
  assign commit       = (state_q == WAIT) && (cnt_q == 3'd0) && !RESET;

  dmem_lane_align #(.DATA_W(DATA_W)) u_lane (
    .size_i   (size_q),
    .off_i    (addr_q[OFF_W-1:0]),
    .wdata_i  (wdata_q),
    .word_i   (mem_q[mem_idx]),
    .be_o     (be),
    .merged_o (merged),
    .rdata_o  (rd_extract)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        state_d = WAIT;
        cnt_d   = CNT_INIT;
      end
      WAIT: if (cnt_q == 3'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 3'd1;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (state_q == IDLE && req_valid) begin
      wr_q    <= req_write;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
    if (commit) begin
      rdata_q <= (wr_q || fault) ? '0 : rd_extract;
      err_q   <= fault;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (commit && wr_q && !fault) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) mem_q[mem_idx][8*b +: 8] <= merged[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_sync_data_memory.sv
// Directed bench for sync_data_memory: latency, lane merge/extract, faults,
// back-to-back handshake, reset abort and alternate-latency builds.
module tb_sync_data_memory;

  localparam int LAT   = 2;
  localparam int DEPTH = 128;

  logic        CLOCK;
  logic        RESET;
  logic        req_valid, v1, v7;
  logic        req_write;
  logic [1:0]  req_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;

  logic        req_ready, resp_valid, resp_err, busy;
  logic [63:0] resp_rdata;
  logic        rdy1, rv1, err1, busy1;
  logic [63:0] rd1;
  logic        rdy7, rv7, err7, busy7;
  logic [63:0] rd7;

  int checks = 0;
  int errors = 0;

  sync_data_memory #(.DATA_W(64), .ADDR_W(64), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  sync_data_memory #(.DATA_W(64), .ADDR_W(64), .DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .CLOCK(CLOCK), .RESET(RESET), .req_valid(v1), .req_ready(rdy1),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1), .busy(busy1)
  );

  sync_data_memory #(.DATA_W(64), .ADDR_W(64), .DEPTH(DEPTH), .LATENCY(7)) dut_l7 (
    .CLOCK(CLOCK), .RESET(RESET), .req_valid(v7), .req_ready(rdy7),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv7), .resp_rdata(rd7), .resp_err(err7), .busy(busy7)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on the main instance; checks the response lands exactly LAT edges later.
  task automatic xact(input string tag, input logic wr, input logic [1:0] sz,
                      input logic [63:0] a, input logic [63:0] wd,
                      input logic [63:0] exp_rd, input logic exp_err);
    chk({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_wdata = wd;
    @(posedge CLOCK); #1;
    req_valid = 1'b0;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    for (int e = 1; e <= LAT; e++) begin
      @(posedge CLOCK); #1;
      if (e < LAT) begin
        chk({tag, "_early_valid"}, {63'd0, resp_valid}, 64'd0);
      end else begin
        chk({tag, "_valid"}, {63'd0, resp_valid}, 64'd1);
        chk({tag, "_rdata"}, resp_rdata, exp_rd);
        chk({tag, "_err"}, {63'd0, resp_err}, {63'd0, exp_err});
      end
    end
    @(posedge CLOCK); #1;
    chk({tag, "_valid_drop"}, {63'd0, resp_valid}, 64'd0);
    chk({tag, "_rdata_idle"}, resp_rdata, 64'd0);
  endtask

  task automatic lat_probe(input int which, input int exp_lat);
    int n;
    n = 0;
    req_write = 1'b0; req_size = 2'd3; req_addr = 64'h10; req_wdata = '0;
    if (which == 1) v1 = 1'b1; else v7 = 1'b1;
    @(posedge CLOCK); #1;
    v1 = 1'b0; v7 = 1'b0;
    do begin
      @(posedge CLOCK); #1;
      n++;
    end while (!((which == 1) ? rv1 : rv7) && n < 20);
    chk((which == 1) ? "lat1_edges" : "lat7_edges", 64'(n), 64'(exp_lat));
    chk((which == 1) ? "lat1_err" : "lat7_err", {63'd0, (which == 1) ? err1 : err7}, 64'd0);
    @(posedge CLOCK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_resp;
    RESET = 1'b1; req_valid = 1'b1; v1 = 1'b0; v7 = 1'b0;
    req_write = 1'b0; req_size = 2'd3; req_addr = 64'h10; req_wdata = '0;

    // Reset with a competing request: it must not be accepted.
    repeat (2) @(posedge CLOCK);
    #1;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_err", {63'd0, resp_err}, 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    RESET = 1'b0; req_valid = 1'b0;
    @(posedge CLOCK); #1;

    xact("st_d10", 1'b1, 2'd3, 64'h10, 64'h1122334455667788, 64'd0, 1'b0);
    xact("ld_d10", 1'b0, 2'd3, 64'h10, 64'd0, 64'h1122334455667788, 1'b0);
    xact("st_b13", 1'b1, 2'd0, 64'h13, 64'hFFFFFFFFFFFFFFAA, 64'd0, 1'b0);
    xact("ld_d10b", 1'b0, 2'd3, 64'h10, 64'd0, 64'h11223344AA667788, 1'b0);
    xact("ld_h16", 1'b0, 2'd1, 64'h16, 64'd0, 64'h1122, 1'b0);
    xact("ld_w14", 1'b0, 2'd2, 64'h14, 64'd0, 64'h11223344, 1'b0);
    xact("ld_b13", 1'b0, 2'd0, 64'h13, 64'd0, 64'hAA, 1'b0);
    xact("ld_w12_mis", 1'b0, 2'd2, 64'h12, 64'd0, 64'd0, 1'b1);
    xact("ld_d11_mis", 1'b0, 2'd3, 64'h11, 64'd0, 64'd0, 1'b1);
    xact("st_d_oor", 1'b1, 2'd3, 64'(DEPTH * 8), 64'hCAFEF00DCAFEF00D, 64'd0, 1'b1);
    xact("ld_d_oor", 1'b0, 2'd3, 64'(DEPTH * 8), 64'd0, 64'd0, 1'b1);
    xact("ld_d0_unch", 1'b0, 2'd3, 64'h0, 64'd0, 64'd0, 1'b0);
    xact("st_h08", 1'b1, 2'd1, 64'h08, 64'h123456789ABCBEEF, 64'd0, 1'b0);
    xact("st_b0f", 1'b1, 2'd0, 64'h0F, 64'h5A, 64'd0, 1'b0);
    xact("ld_d08", 1'b0, 2'd3, 64'h08, 64'd0, 64'h5A0000000000BEEF, 1'b0);
    xact("ld_d10_unch", 1'b0, 2'd3, 64'h10, 64'd0, 64'h11223344AA667788, 1'b0);

    // req_valid held high across two back-to-back loads.
    n_resp = 0;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_addr = 64'h10;
    for (int c = 0; c < 2; c++) begin
      @(posedge CLOCK); #1;
      for (int i = 0; i <= LAT; i++) begin
        chk("hold_ready_low", {63'd0, req_ready}, 64'd0);
        if (resp_valid) begin
          n_resp++;
          chk("hold_rdata", resp_rdata, 64'h11223344AA667788);
        end
        @(posedge CLOCK); #1;
      end
      chk("hold_ready_back", {63'd0, req_ready}, 64'd1);
    end
    req_valid = 1'b0;
    chk("hold_resp_count", 64'(n_resp), 64'd2);
    @(posedge CLOCK); #1;

    // Reset on the commit edge of a store aborts it.
    xact("st_d20", 1'b1, 2'd3, 64'h20, 64'h0123456789ABCDEF, 64'd0, 1'b0);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_addr = 64'h20;
    req_wdata = 64'hFFFFFFFFFFFFFFFF;
    @(posedge CLOCK); #1;
    req_valid = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      @(posedge CLOCK); #1;
    end
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    chk("abort_valid", {63'd0, resp_valid}, 64'd0);
    chk("abort_ready", {63'd0, req_ready}, 64'd1);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    n_resp = 0;
    repeat (3) begin
      @(posedge CLOCK); #1;
      if (resp_valid) n_resp++;
    end
    chk("abort_no_pulse", 64'(n_resp), 64'd0);
    xact("ld_d20_prior", 1'b0, 2'd3, 64'h20, 64'd0, 64'h0123456789ABCDEF, 1'b0);

    lat_probe(1, 1);
    lat_probe(7, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
